// File: rtl/psg_register_interface_if.sv
// CPU write bus plus generator-facing register outputs of the PSG register
// interface. The master modport is the CPU side and the slave modport is the
// register block.
interface psg_register_interface_if #(
  parameter int TONE_FREQUENCY_BITS      = 10,
  parameter int ATTENUATION_CONTROL_BITS = 4,
  parameter int NOISE_CONTROL_BITS       = 3
);
  logic [7:0]                            data;
  logic                                  we_n;
  logic                                  ready;
  logic [4*ATTENUATION_CONTROL_BITS-1:0] attn;
  logic [3*TONE_FREQUENCY_BITS-1:0]      tone_freq;
  logic [NOISE_CONTROL_BITS-1:0]         noise_ctrl;
  logic                                  noise_reset;
  logic                                  write_dropped;

  modport master (
    output data, we_n,
    input  ready, attn, tone_freq, noise_ctrl, noise_reset, write_dropped
  );

  modport slave (
    input  data, we_n,
    output ready, attn, tone_freq, noise_ctrl, noise_reset, write_dropped
  );
endinterface

// File: rtl/psg_register_interface.sv
// SN76489-style CPU write port: decodes latch/data bytes into attenuation,
// tone-period and noise-control registers, pulses the noise LFSR reset and
// holds READY low for BUSY_CYCLES clocks after each accepted write.
// Optional macro PSG_INPUT_SYNC_EN adds a 2-flop synchronizer on we_n/data,
// adding two cycles of accept latency.
module psg_register_interface #(
  parameter int BUSY_CYCLES              = 32,
  parameter int TONE_FREQUENCY_BITS      = 10,
  parameter int ATTENUATION_CONTROL_BITS = 4,
  parameter int NOISE_CONTROL_BITS       = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  psg_register_interface_if.slave   bus
);

  localparam logic [5:0] BUSY_LOAD = 6'(BUSY_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } busy_state_e;

  // Write-side view of the bus after optional synchronization.
  logic [7:0] data_s;
  logic       we_n_s;

`ifdef PSG_INPUT_SYNC_EN
  logic [1:0] we_sync_q;
  logic [7:0] data_sync1_q;
  logic [7:0] data_sync2_q;

  // Two-stage synchronizer for the asynchronous CPU strobe and byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_sync_q    <= 2'b11;
      data_sync1_q <= 8'h00;
      data_sync2_q <= 8'h00;
    end else begin
      we_sync_q    <= {we_sync_q[0], bus.we_n};
      data_sync1_q <= bus.data;
      data_sync2_q <= data_sync1_q;
    end
  end

  assign we_n_s = we_sync_q[1];
  assign data_s = data_sync2_q;
`else
  assign we_n_s = bus.we_n;
  assign data_s = bus.data;
`endif

  logic        we_prev_q;
  logic        ready_q;
  logic        write_dropped_q;
  busy_state_e state_q;
  logic [5:0]  cnt_q;

  logic [3:0][ATTENUATION_CONTROL_BITS-1:0] attn_q;
  logic [2:0][TONE_FREQUENCY_BITS-1:0]      tone_q;
  logic [NOISE_CONTROL_BITS-1:0]            noise_q;
  logic                                     noise_reset_q;
  logic [1:0]                               latch_chan_q;
  logic                                     latch_type_q;

  // Falling-edge detect on the (possibly synchronized) strobe.
  logic write_det;
  logic accept;
  logic drop;

  assign write_det = ~we_n_s & we_prev_q;
  assign accept    = write_det & ready_q;
  assign drop      = write_det & ~ready_q;

  // Latch bytes carry their own target; data bytes reuse the stored latch.
  logic       is_latch;
  logic [1:0] tgt_chan;
  logic       tgt_type;

  assign is_latch = data_s[7];
  assign tgt_chan = is_latch ? data_s[6:5] : latch_chan_q;
  assign tgt_type = is_latch ? data_s[4]   : latch_type_q;

  // Track the previous strobe level every cycle, busy or not.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      we_prev_q <= 1'b1;
    end else begin
      we_prev_q <= we_n_s;
    end
  end

  // Register file update on accepted writes, plus the noise reset pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attn_q        <= '1;
      tone_q        <= '0;
      noise_q       <= '0;
      noise_reset_q <= 1'b0;
      latch_chan_q  <= 2'd0;
      latch_type_q  <= 1'b0;
    end else begin
      noise_reset_q <= 1'b0;
      if (accept) begin
        if (is_latch) begin
          latch_chan_q <= data_s[6:5];
          latch_type_q <= data_s[4];
        end
        if (tgt_type) begin
          attn_q[tgt_chan] <= data_s[ATTENUATION_CONTROL_BITS-1:0];
        end else if (tgt_chan == 2'd3) begin
          noise_q       <= data_s[NOISE_CONTROL_BITS-1:0];
          noise_reset_q <= 1'b1;
        end else if (is_latch) begin
          tone_q[tgt_chan][3:0] <= data_s[3:0];
        end else begin
          tone_q[tgt_chan][TONE_FREQUENCY_BITS-1:4] <= data_s[TONE_FREQUENCY_BITS-5:0];
        end
      end
    end
  end

  // Busy FSM: holds READY low for BUSY_CYCLES clocks after an accept and
  // records strobes that arrive while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 6'd0;
      ready_q         <= 1'b1;
      write_dropped_q <= 1'b0;
    end else begin
      if (drop) begin
        write_dropped_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept && (BUSY_CYCLES > 0)) begin
            state_q <= ST_BUSY;
            cnt_q   <= BUSY_LOAD;
            ready_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready         = ready_q;
  assign bus.write_dropped = write_dropped_q;
  assign bus.attn          = attn_q;
  assign bus.tone_freq     = tone_q;
  assign bus.noise_ctrl    = noise_q;
  assign bus.noise_reset   = noise_reset_q;

endmodule

// File: tb/tb_psg_register_interface.sv
// Directed bench for psg_register_interface: one instance with the default
// busy time and one with BUSY_CYCLES = 0.
module tb_psg_register_interface;

  localparam int BUSY = 32;
`ifdef PSG_INPUT_SYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  logic clk;
  logic reset;
  logic reset0;

  int n_checks = 0;
  int n_fail   = 0;

  psg_register_interface_if bus32 ();
  psg_register_interface_if bus0 ();

  psg_register_interface #(.BUSY_CYCLES(BUSY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  psg_register_interface #(.BUSY_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset0),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One-cycle strobe on the busy instance; returns at the negedge after the
  // edge on which the register update becomes visible.
  task automatic write32(input logic [7:0] b);
    @(posedge clk); #1;
    bus32.we_n = 1'b0;
    bus32.data = b;
    @(posedge clk); #1;
    bus32.we_n = 1'b1;
    repeat (SYNC_EXTRA) @(posedge clk);
    @(negedge clk);
  endtask

  // Counts low-ready cycles starting at the negedge after an accept.
  task automatic measure_busy(input string tag);
    int n = 0;
    while (bus32.ready === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, BUSY);
  endtask

  task automatic wait_ready32(input string tag);
    int n = 0;
    while (bus32.ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(tag, bus32.ready, 1'b1);
  endtask

  logic [7:0] burst [4] = '{8'h81, 8'hA3, 8'hC7, 8'h12};

  initial begin
    reset      = 1'b1;
    reset0     = 1'b1;
    bus32.we_n = 1'b1;
    bus32.data = 8'h00;
    bus0.we_n  = 1'b1;
    bus0.data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    reset0 = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_attn",     bus32.attn,          16'hFFFF);
    check("rst_tone",     bus32.tone_freq,     30'h0);
    check("rst_noise",    bus32.noise_ctrl,    3'b000);
    check("rst_nreset",   bus32.noise_reset,   1'b0);
    check("rst_ready",    bus32.ready,         1'b1);
    check("rst_dropped",  bus32.write_dropped, 1'b0);

    // Tone 0: latch low nibble then data high bits
    write32(8'h8E);
    check("tone_lo",      bus32.tone_freq, 30'h00E);
    check("tone_lo_rdy",  bus32.ready,     1'b0);
    measure_busy("busy_len_1");
    write32(8'h0F);
    check("tone_full",    bus32.tone_freq, 30'h0FE);
    measure_busy("busy_len_2");

    // Channel 1 volume via latch, then via data byte
    write32(8'hB5);
    check("attn_ch1_5",   bus32.attn, 16'hFF5F);
    wait_ready32("rdy_b5");
    write32(8'h0A);
    check("attn_ch1_A",   bus32.attn, 16'hFFAF);
    wait_ready32("rdy_0a");

    // Noise register via latch and data byte, each with one pulse
    write32(8'hE6);
    check("noise_e6",     bus32.noise_ctrl,  3'b110);
    check("nrst_e6",      bus32.noise_reset, 1'b1);
    @(negedge clk);
    check("nrst_e6_end",  bus32.noise_reset, 1'b0);
    check("tone_keep",    bus32.tone_freq,   30'h0FE);
    wait_ready32("rdy_e6");
    write32(8'h03);
    check("noise_03",     bus32.noise_ctrl,  3'b011);
    check("nrst_03",      bus32.noise_reset, 1'b1);
    @(negedge clk);
    check("nrst_03_end",  bus32.noise_reset, 1'b0);
    wait_ready32("rdy_03");
    // Same value with data[3] set: bit 3 ignored, pulse still fires
    write32(8'hEB);
    check("noise_eb",     bus32.noise_ctrl,  3'b011);
    check("nrst_same",    bus32.noise_reset, 1'b1);
    check("attn_keep",    bus32.attn,        16'hFFAF);
    wait_ready32("rdy_eb");

    // Dropped write while busy, strobe held low across end of busy
    write32(8'h9F);
    repeat (4) @(posedge clk);
    #1;
    bus32.we_n = 1'b0;
    bus32.data = 8'h90;
    wait_ready32("rdy_drop");
    repeat (6) @(negedge clk);
    check("drop_attn",    bus32.attn,          16'hFFAF);
    check("drop_flag",    bus32.write_dropped, 1'b1);
    check("drop_noreacc", bus32.ready,         1'b1);
    bus32.we_n = 1'b1;
    repeat (4) @(negedge clk);
    check("drop_sticky",  bus32.write_dropped, 1'b1);
    check("drop_attn2",   bus32.attn,          16'hFFAF);

    // Zero busy: data byte right after reset hits tone 0 high bits, with
    // the expected detection latency
    @(posedge clk); #1;
    bus0.we_n = 1'b0;
    bus0.data = 8'h15;
    repeat (SYNC_EXTRA) @(posedge clk);
    @(negedge clk);
    check("z_pre_update", bus0.tone_freq, 30'h0);
    @(negedge clk);
    check("z_post_update", bus0.tone_freq, 30'h150);
    check("z_ready",      bus0.ready,     1'b1);
    bus0.we_n = 1'b1;
    @(negedge clk);

    // Strobes on every other cycle, all accepted
    foreach (burst[i]) begin
      @(posedge clk); #1;
      bus0.we_n = 1'b0;
      bus0.data = burst[i];
      @(posedge clk); #1;
      bus0.we_n = 1'b1;
    end
    repeat (SYNC_EXTRA + 1) @(posedge clk);
    @(negedge clk);
    check("z_burst_tone", bus0.tone_freq, {10'h127, 10'h003, 10'h151});
    check("z_burst_rdy",  bus0.ready,     1'b1);
    check("z_burst_drop", bus0.write_dropped, 1'b0);

    // Reset asserted mid-sequence
    @(posedge clk); #1;
    bus0.we_n = 1'b0;
    bus0.data = 8'hBC;
    @(posedge clk); #1;
    bus0.we_n = 1'b1;
    #2;
    reset0 = 1'b1;
    #1;
    check("z_rst_attn",   bus0.attn,       16'hFFFF);
    check("z_rst_tone",   bus0.tone_freq,  30'h0);
    check("z_rst_noise",  bus0.noise_ctrl, 3'b000);
    check("z_rst_ready",  bus0.ready,      1'b1);
    @(negedge clk);
    reset0 = 1'b0;
    repeat (4) @(negedge clk);
    check("z_rst_hold",   bus0.attn,       16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
